fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction fetch queue between the PC/IMEM fetch stage and the decode stage.
//  It buffers up to DEPTH fetched entries {pc, pc+4, instr}, and back-pressures the PC when full.
//  It presents entries to decode in first-word-fall-through order.
//  A branch redirect (flush) discards every buffered entry.
// PARAMETERS
//  XLEN       32             data/address width
//  DEPTH      4              entries; power of two, >= 2
//  NOP_INSTR  32'h0000_0013  instr driven on d_instr_o when empty (addi x0,x0,0)
// PORTS
//  clk_i      in   1             clock; all state updates on rising edge
//  rst_ni     in   1             reset, asynchronous, active-low
//  flush_i    in   1             branch redirect; drop all entries
//  f_valid_i  in   1             fetch stage presents an entry
//  f_ready_o  out  1             queue accepts an entry (= count < DEPTH)
//  f_pc_i     in   XLEN          PC of fetched instr
//  f_pc4_i    in   XLEN          PC+4 of fetched instr
//  f_instr_i  in   XLEN          fetched instruction word
//  d_valid_o  out  1             head entry valid (= count != 0)
//  d_ready_i  in   1             decode consumes head entry
//  d_pc_o     out  XLEN          head PC (0 when empty)
//  d_pc4_o    out  XLEN          head PC+4 (0 when empty)
//  d_instr_o  out  XLEN          head instr (NOP_INSTR when empty)
//  count_o    out  clog2(DEPTH+1) occupied entries
// BEHAVIOUR
//  State: wr_ptr, rd_ptr (log2 DEPTH bits), count, and storage[DEPTH].
//  Reset (rst_ni=0, async): ptrs=0, count=0, storage=0.
//    Outputs: f_ready_o=1, d_valid_o=0, d_pc_o=0, d_pc4_o=0, d_instr_o=NOP_INSTR, count_o=0.
//  push = f_valid_i & f_ready_o & ~flush_i; write storage[wr_ptr], wr_ptr+1 (mod DEPTH).
//  pop  = d_valid_o & d_ready_i & ~flush_i; rd_ptr+1 (mod DEPTH).
//  count_next = count + push - pop; push&pop together -> count unchanged.
//  Latency: a pushed entry appears on d_* one cycle after the push edge. No comb bypass from f_* to d_*.
//  d_* driven combinationally from storage[rd_ptr] gated by d_valid_o (FWFT).
//  f_ready_o and d_valid_o depend only on registered count; no comb path from d_ready_i to f_ready_o.
//  Full (count==DEPTH): f_ready_o=0; f_valid_i ignored even if pop occurs the same cycle.
//  Empty (count==0): d_valid_o=0; d_ready_i ignored; d_* show empty defaults.
//  Flush: at the next edge, ptrs=0 and count=0.
//    Any same-cycle push and pop are discarded.
//    Storage contents are don't-care.
//    Entries fetched from the redirected PC are accepted from the cycle after flush.
//  Wrap-around: ptrs wrap DEPTH-1 -> 0; ordering is preserved across the wrap.
//  Reset asserted mid-operation: immediate clear per the reset values above, regardless of clk_i.
//  Data is not inspected; no handling of instruction type.
// TESTING
//  1. Reset: rst_ni=0 mid-cycle with 3 entries held.
//     -> count_o=0, d_valid_o=0, d_instr_o=32'h00000013, f_ready_o=1 immediately.
//  2. Fill: d_ready_i=0, push pc=0x0,0x4,0x8,0xC.
//     -> count_o=4, f_ready_o=0; 5th f_valid_i (pc=0x10) is not stored.
//  3. Drain order: from full, d_ready_i=1 for 4 cycles.
//     -> d_pc_o=0x0,0x4,0x8,0xC; d_pc4_o=pc+4; then d_valid_o=0.
//  4. Streaming: f_valid_i=1, d_ready_i=1 continuously, pc stepping by 4 for 10 cycles.
//     -> count_o holds 1 after the first cycle; ptrs wrap twice; order intact.
//  5. Flush: 3 entries held, flush_i=1 with push and pop asserted.
//     -> next cycle count_o=0, d_valid_o=0.
//     -> push pc=0x12345600 next cycle, then d_pc_o=0x12345600.
//  6. Full+pop: count=4, f_valid_i=1, d_ready_i=1.
//     -> count_o=3, pushed data is not stored, head advances.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the fetch stage and decode.
// First-word-fall-through FIFO of {pc, pc+4, instr} entries, emptied by a branch redirect.
module fetch_queue #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         f_valid_i,
  output logic                         f_ready_o,
  input  logic [XLEN-1:0]              f_pc_i,
  input  logic [XLEN-1:0]              f_pc4_i,
  input  logic [XLEN-1:0]              f_instr_i,
  output logic                         d_valid_o,
  input  logic                         d_ready_i,
  output logic [XLEN-1:0]              d_pc_o,
  output logic [XLEN-1:0]              d_pc4_o,
  output logic [XLEN-1:0]              d_instr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t        r_storage [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic   w_push;
  logic   w_pop;
  entry_t w_head;

  // Handshakes come from the registered count only, so d_ready_i never reaches f_ready_o.
  assign f_ready_o = (r_count != CW'(DEPTH));
  assign d_valid_o = (r_count != '0);
  assign count_o   = r_count;

  assign w_push = f_valid_i & f_ready_o & ~flush_i;
  assign w_pop  = d_valid_o & d_ready_i & ~flush_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is explicitly cleared on reset because the queue
  // contents are defined as zero afterwards; this costs a reset net per bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_storage[i] <= '0;
    end else if (w_push) begin
      r_storage[r_wr_ptr] <= '{pc: f_pc_i, pc4: f_pc4_i, instr: f_instr_i};
    end
  end

  assign w_head = r_storage[r_rd_ptr];

  // NOTE: every always_comb output is given a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    d_pc_o    = '0;
    d_pc4_o   = '0;
    d_instr_o = NOP_INSTR;
    if (d_valid_o) begin
      d_pc_o    = w_head.pc;
      d_pc4_o   = w_head.pc4;
      d_instr_o = w_head.instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus queues expected entries,
// a negedge monitor checks every entry decode consumes.
module tb_fetch_queue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] f_pc;
  logic [31:0] f_pc4;
  logic [31:0] f_instr;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_pc;
  logic [31:0] d_pc4;
  logic [31:0] d_instr;
  logic [2:0]  count;

  int   n_tests;
  int   n_failed;
  exp_t exp_q[$];

  fetch_queue dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .flush_i   (flush),
    .f_valid_i (f_valid),
    .f_ready_o (f_ready),
    .f_pc_i    (f_pc),
    .f_pc4_i   (f_pc4),
    .f_instr_i (f_instr),
    .d_valid_o (d_valid),
    .d_ready_i (d_ready),
    .d_pc_o    (d_pc),
    .d_pc4_o   (d_pc4),
    .d_instr_o (d_instr),
    .count_o   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  // Present one fetch entry; expected=1 means the queue must accept it.
  task automatic drive_fetch(input logic [31:0] pc, input bit expected);
    f_valid = 1'b1;
    f_pc    = pc;
    f_pc4   = pc + 32'd4;
    f_instr = instr_of(pc);
    if (expected) exp_q.push_back('{pc: pc, pc4: pc + 32'd4, instr: instr_of(pc)});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed head entry must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && d_valid && d_ready && !flush) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_failed++;
        $display("FAIL pop_unexpected: got pc 0x%08h expected no entry", d_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_pc", d_pc, e.pc);
        check("pop_pc4", d_pc4, e.pc4);
        check("pop_instr", d_instr, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    f_valid  = 1'b0;
    f_pc     = '0;
    f_pc4    = '0;
    f_instr  = '0;
    d_ready  = 1'b0;
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_f_ready", 32'(f_ready), 32'd1);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_d_instr", d_instr, 32'h0000_0013);
    check("rst_d_pc", d_pc, 32'd0);
    check("rst_d_pc4", d_pc4, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Fill to full, then a fifth fetch must be refused.
    for (int i = 0; i < 4; i++) begin
      drive_fetch(32'(i * 4), 1'b1);
      cyc();
    end
    f_valid = 1'b0;
    check("fill_count", 32'(count), 32'd4);
    check("fill_f_ready", 32'(f_ready), 32'd0);
    drive_fetch(32'h10, 1'b0);
    cyc();
    f_valid = 1'b0;
    check("full_count_hold", 32'(count), 32'd4);
    check("full_head_pc", d_pc, 32'h0);

    // Drain in order.
    d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", d_pc, 32'(i * 4));
      check("drain_pc4", d_pc4, 32'(i * 4 + 4));
      cyc();
    end
    check("drain_d_valid", 32'(d_valid), 32'd0);
    check("empty_d_instr", d_instr, 32'h0000_0013);
    check("empty_d_pc", d_pc, 32'd0);
    cyc();
    check("empty_pop_ignored", 32'(count), 32'd0);

    // Streaming through two pointer wraps.
    for (int i = 0; i < 10; i++) begin
      drive_fetch(32'h100 + 32'(i * 4), 1'b1);
      cyc();
      check("stream_count", 32'(count), 32'd1);
    end
    f_valid = 1'b0;
    cyc();
    check("stream_drained", 32'(count), 32'd0);
    d_ready = 1'b0;

    // Flush with a simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin
      drive_fetch(32'h200 + 32'(i * 4), 1'b1);
      cyc();
    end
    check("preflush_count", 32'(count), 32'd3);
    drive_fetch(32'h20C, 1'b0);
    d_ready = 1'b1;
    flush   = 1'b1;
    cyc();
    flush   = 1'b0;
    f_valid = 1'b0;
    d_ready = 1'b0;
    exp_q.delete();
    check("flush_count", 32'(count), 32'd0);
    check("flush_d_valid", 32'(d_valid), 32'd0);
    drive_fetch(32'h1234_5600, 1'b1);
    cyc();
    f_valid = 1'b0;
    check("redirect_pc", d_pc, 32'h1234_5600);
    check("redirect_count", 32'(count), 32'd1);
    d_ready = 1'b1;
    cyc();
    d_ready = 1'b0;
    check("redirect_drained", 32'(count), 32'd0);

    // Full with simultaneous pop: push refused, head advances.
    for (int i = 0; i < 4; i++) begin
      drive_fetch(32'h300 + 32'(i * 4), 1'b1);
      cyc();
    end
    check("full2_count", 32'(count), 32'd4);
    drive_fetch(32'h310, 1'b0);
    d_ready = 1'b1;
    cyc();
    f_valid = 1'b0;
    d_ready = 1'b0;
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_head", d_pc, 32'h304);
    d_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    d_ready = 1'b0;
    check("fullpop_drained", 32'(count), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-cycle with three entries held.
    for (int i = 0; i < 3; i++) begin
      drive_fetch(32'h400 + 32'(i * 4), 1'b1);
      cyc();
    end
    f_valid = 1'b0;
    check("prereset_count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_d_valid", 32'(d_valid), 32'd0);
    check("async_rst_d_instr", d_instr, 32'h0000_0013);
    check("async_rst_f_ready", 32'(f_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    cyc();
    check("post_rst_count", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
